// File: rtl/metronomo_pkg.sv
// Shared types and constants for the metronome tempo path.
// Tap-tempo FSM states and the BPM / period limits used when converting a tap interval.
package metronomo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2,
    DONE    = 2'd3
  } tap_state_t;

  localparam logic [7:0]  BPM_MIN       = 8'd40;
  localparam logic [7:0]  BPM_MAX       = 8'd240;
  localparam logic [7:0]  BPM_RESET     = 8'd60;
  localparam logic [15:0] MS_PER_MIN    = 16'd60000;
  localparam logic [15:0] PERIOD_MIN_MS = 16'd250;
  localparam logic [15:0] PERIOD_MAX_MS = 16'd1500;

  // Divisor floor: keeps the quotient within 8 bits and rules out divide-by-zero.
  function automatic logic [15:0] divisor_of(input logic [15:0] period_ms);
    return (period_ms < PERIOD_MIN_MS) ? PERIOD_MIN_MS : period_ms;
  endfunction

endpackage

// File: rtl/debounce_m.sv
// Two-flop synchronizer plus stability counter for a mechanical button.
// level_o follows raw_i once it has held a new value for STABLE_CYCLES; rise_o marks the 0->1 change.
module debounce_m #(
  parameter int unsigned STABLE_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter restarts whenever the synchronized input agrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_o  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_o  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/tap_tempo_m.sv
// Tap-tempo front end: measures ms between accepted taps and converts the interval to BPM
// with a 16-step restoring divider; bpm_valid pulses for one cycle on every new value.
module tap_tempo_m
  import metronomo_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TIMEOUT_MS  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tap,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int unsigned PRESC = CLK_HZ / 1000;
  localparam int unsigned PW    = $clog2(PRESC + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [15:0]   TIMEOUT_W  = 16'(TIMEOUT_MS);

  tap_state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   period_q, period_d;
  logic [15:0]   divisor_q, divisor_d;
  logic          lo_q, lo_d;
  logic          hi_q, hi_d;
  logic [15:0]   rem_q, rem_d;
  logic [15:0]   dvd_q, dvd_d;
  logic [15:0]   quo_q, quo_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    bpm_q, bpm_d;
  logic          valid_q, valid_d;

  logic          tap_level;
  logic          tap_acc;
  logic          ms_tick;
  logic [16:0]   rem_shift;
  logic          fits;
  logic [15:0]   rem_sub;

  debounce_m #(
    .STABLE_CYCLES(DEBOUNCE_MS * PRESC)
  ) u_debounce (
    .clk_i  (clk),
    .rst_i  (rst),
    .raw_i  (tap),
    .level_o(tap_level),
    .rise_o (tap_acc)
  );

  assign ms_tick   = (presc_q == PRESC_LAST);
  assign rem_shift = {rem_q, dvd_q[15]};
  assign fits      = (rem_shift >= {1'b0, divisor_q});
  // When fits is set the true difference is below divisor, so 16 bits are exact.
  assign rem_sub   = rem_shift[15:0] - divisor_q;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    period_d  = period_q;
    divisor_d = divisor_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    quo_d     = quo_q;
    bit_d     = bit_q;
    bpm_d     = bpm_q;
    valid_d   = 1'b0;

    if (state_q == IDLE) begin
      presc_d  = '0;
      period_d = '0;
    end else if (ms_tick) begin
      presc_d  = '0;
      period_d = period_q + 16'd1;
    end else begin
      presc_d  = presc_q + 1'b1;
    end
    if (tap_acc) begin
      presc_d  = '0;
      period_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (tap_acc) state_d = MEASURE;
      end
      MEASURE: begin
        if (tap_acc) begin
          divisor_d = divisor_of(period_q);
          lo_d      = (period_q > PERIOD_MAX_MS);
          hi_d      = (period_q < PERIOD_MIN_MS);
          rem_d     = '0;
          dvd_d     = MS_PER_MIN;
          quo_d     = '0;
          bit_d     = '0;
          state_d   = DIVIDE;
        end else if (period_q >= TIMEOUT_W) begin
          state_d = IDLE;
        end
      end
      DIVIDE: begin
        rem_d = fits ? rem_sub : rem_shift[15:0];
        quo_d = {quo_q[14:0], fits};
        dvd_d = {dvd_q[14:0], 1'b0};
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        if (hi_q || (quo_q > {8'd0, BPM_MAX})) bpm_d = BPM_MAX;
        else if (lo_q)                         bpm_d = BPM_MIN;
        else                                   bpm_d = quo_q[7:0];
        valid_d = 1'b1;
        state_d = MEASURE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      period_q  <= '0;
      divisor_q <= PERIOD_MIN_MS;
      lo_q      <= 1'b0;
      hi_q      <= 1'b0;
      rem_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      bit_q     <= '0;
      bpm_q     <= BPM_RESET;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      period_q  <= period_d;
      divisor_q <= divisor_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      quo_q     <= quo_d;
      bit_q     <= bit_d;
      bpm_q     <= bpm_d;
      valid_q   <= valid_d;
    end
  end

  // The released level is tracked by the debouncer but only its rising edge matters here.
  logic unused_level;
  assign unused_level = tap_level;

  assign bpm       = bpm_q;
  assign bpm_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tap_tempo_m.sv
// Self-checking bench for tap_tempo_m at 10 cycles/ms with a 2 ms debounce.
// Expected BPM comes from a plain interval-to-tempo model; edges are counted in cyc.
module tb_tap_tempo_m;
  import metronomo_pkg::*;

  localparam int CYC_PER_MS = 10;
  localparam int DEB_CYC    = 2 * CYC_PER_MS;
  localparam int ACC_LAT    = 2 + DEB_CYC;
  localparam int DONE_LAT   = 17;
  localparam int TO_CYC     = 2000 * CYC_PER_MS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tap = 1'b0;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       busy;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_seen = 0;
  int valid_exp = 0;
  int last_acc = 0;
  logic [7:0] last_bpm = 8'd60;
  logic [7:0] exp_q[$];

  tap_tempo_m #(
    .CLK_HZ     (10_000),
    .DEBOUNCE_MS(2),
    .TIMEOUT_MS (2000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tap      (tap),
    .bpm      (bpm),
    .bpm_valid(bpm_valid),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    if (bpm_valid === 1'b1) valid_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // period_ms at the accepting edge counts whole ms completed since the previous accepted edge.
  function automatic logic [7:0] ref_bpm(input int d);
    int p;
    p = (d - 1) / CYC_PER_MS;
    if (p < 250)  return 8'd240;
    if (p > 1500) return 8'd40;
    return 8'(60000 / p);
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(input int t, output int acc);
    wait_until(t);
    tap = 1'b1;
    acc = t + ACC_LAT;
    wait_until(t + 25);
    tap = 1'b0;
  endtask

  task automatic run_interval(input int d, input string name);
    int acc;
    logic [7:0] e;
    press(last_acc + d - ACC_LAT, acc);
    e = ref_bpm(acc - last_acc);
    exp_q.push_back(e);
    valid_exp++;
    wait_until(acc + DONE_LAT - 1);
    total++;
    if (bpm_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s early_valid: got %b want 0", name, bpm_valid);
    end
    wait_until(acc + DONE_LAT);
    total++;
    if (bpm_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s valid: got %b want 1", name, bpm_valid);
    end
    e = exp_q.pop_front();
    total++;
    if (bpm !== e) begin
      bad++;
      $display("FAIL %s bpm: got %0d want %0d", name, bpm, e);
    end
    wait_until(acc + DONE_LAT + 1);
    total++;
    if (bpm_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s valid_drop: got %b want 0", name, bpm_valid);
    end
    last_acc = acc;
    last_bpm = e;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bpm !== 8'd60) begin bad++; $display("FAIL reset_bpm: got %0d want 60", bpm); end
    total++;
    if (bpm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bpm_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_bounce();
    int t0, acc, t1;
    t0 = cyc + 5;
    wait_until(t0);      tap = 1'b1;
    wait_until(t0 + 5);  tap = 1'b0;
    wait_until(t0 + 10); tap = 1'b1;
    acc = t0 + 10 + ACC_LAT;
    wait_until(acc - 1);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bounce_early: busy got %b want 0", busy); end
    wait_until(acc);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL bounce_accept: busy got %b want 1", busy); end
    wait_until(t0 + 10 + 50);
    tap = 1'b0;
    wait_until(acc + 80);
    total++;
    if (dbg_state !== MEASURE) begin bad++; $display("FAIL bounce_single: state got %0d want %0d", dbg_state, MEASURE); end
    t1 = cyc + 20;
    wait_until(t1);      tap = 1'b1;
    wait_until(t1 + 10); tap = 1'b0;
    wait_until(t1 + 60);
    total++;
    if (dbg_state !== MEASURE) begin bad++; $display("FAIL glitch_state: got %0d want %0d", dbg_state, MEASURE); end
    total++;
    if (valid_seen !== valid_exp) begin bad++; $display("FAIL glitch_valid: pulses got %0d want %0d", valid_seen, valid_exp); end
    last_acc = acc;
  endtask

  task automatic test_nominal();
    run_interval(500 * CYC_PER_MS, "nom500");
    total++;
    if (bpm !== 8'd120) begin bad++; $display("FAIL nom500_abs: got %0d want 120", bpm); end
    run_interval(600 * CYC_PER_MS, "nom600");
    run_interval(400 * CYC_PER_MS, "nom400");
    total++;
    if (bpm !== 8'd150) begin bad++; $display("FAIL nom400_abs: got %0d want 150", bpm); end
  endtask

  task automatic test_random();
    run_interval(int'($urandom_range(2510, 3200)), "rand_a");
    run_interval(int'($urandom_range(300, 2400)), "rand_b");
    run_interval(int'($urandom_range(3300, 4000)), "rand_c");
  endtask

  task automatic test_clamp();
    run_interval(100 * CYC_PER_MS, "clamp100");
    run_interval(1800 * CYC_PER_MS, "clamp1800");
    run_interval(250 * CYC_PER_MS, "edge250");
    total++;
    if (bpm !== 8'd240) begin bad++; $display("FAIL edge250_abs: got %0d want 240", bpm); end
    run_interval(1500 * CYC_PER_MS, "edge1500");
    total++;
    if (bpm !== 8'd40) begin bad++; $display("FAIL edge1500_abs: got %0d want 40", bpm); end
  endtask

  task automatic test_timeout();
    int a1;
    wait_until(last_acc + TO_CYC);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL timeout_early: busy got %b want 1", busy); end
    wait_until(last_acc + TO_CYC + 1);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL timeout_state: got %0d want %0d", dbg_state, IDLE); end
    total++;
    if (bpm !== last_bpm) begin bad++; $display("FAIL timeout_bpm: got %0d want %0d", bpm, last_bpm); end
    total++;
    if (valid_seen !== valid_exp) begin bad++; $display("FAIL timeout_valid: pulses got %0d want %0d", valid_seen, valid_exp); end
    press(cyc + 10, a1);
    last_acc = a1;
    run_interval(750 * CYC_PER_MS, "pair750");
    total++;
    if (bpm !== 8'd80) begin bad++; $display("FAIL pair750_abs: got %0d want 80", bpm); end
  endtask

  task automatic test_reset_mid_divide();
    int acc;
    press(last_acc + 50 * CYC_PER_MS - ACC_LAT, acc);
    wait_until(acc + 5);
    total++;
    if (dbg_state !== DIVIDE) begin bad++; $display("FAIL middiv_state: got %0d want %0d", dbg_state, DIVIDE); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bpm !== 8'd60) begin bad++; $display("FAIL async_bpm: got %0d want 60", bpm); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", busy); end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL async_state: got %0d want %0d", dbg_state, IDLE); end
    wait_until(acc + 8);
    rst = 1'b0;
    wait_until(acc + 40);
    total++;
    if (valid_seen !== valid_exp) begin bad++; $display("FAIL middiv_valid: pulses got %0d want %0d", valid_seen, valid_exp); end
    total++;
    if (bpm !== 8'd60) begin bad++; $display("FAIL middiv_bpm: got %0d want 60", bpm); end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL middiv_idle: got %0d want %0d", dbg_state, IDLE); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_bounce();
    test_nominal();
    test_random();
    test_clamp();
    test_timeout();
    test_reset_mid_divide();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    total++;
    if (valid_seen !== valid_exp) begin bad++; $display("FAIL pulse_count: got %0d want %0d", valid_seen, valid_exp); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
